// File: rtl/calc_pkg.sv
// Shared types for the calculator arbiter: operation codes, FSM states and a
// small helper that turns a requester index into a one-hot vector.
package calc_pkg;

    typedef enum logic [1:0] {
        ADD      = 2'b00,
        SUBTRACT = 2'b01,
        OR       = 2'b10,
        EQUALS   = 2'b11
    } calc_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } calc_state_t;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational next-accumulator computation for one latched operation.
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  calc_op_t         op,
    output logic [WIDTH-1:0] next_acc
);

    always_comb begin
        next_acc = acc;
        case (op)
            ADD:      next_acc = acc + operand;
            SUBTRACT: next_acc = acc - operand;
            OR:       next_acc = acc | operand;
            EQUALS: begin
                // Comparison result lands in bit 0, all upper bits cleared.
                next_acc    = '0;
                next_acc[0] = (acc == operand);
            end
            default:  next_acc = acc;
        endcase
    end

endmodule

// File: rtl/calc_arbiter.sv
// Two-requester arbiter sharing one accumulator: round-robin grant with an
// optional ownership lock, and a fixed three-cycle IDLE/EXEC/DONE operation.
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       lock,
    input  calc_op_t         op0,
    input  calc_op_t         op1,
    input  logic [WIDTH-1:0] operand0,
    input  logic [WIDTH-1:0] operand1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    calc_state_t      state;
    calc_state_t      state_next;
    logic             owner;
    logic             rr;
    logic             lock_active;
    logic             lock_owner;
    calc_op_t         op_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_next;
    logic [1:0]       eligible;
    logic             grant_valid;
    logic             grant_idx;
    calc_op_t         grant_op;
    logic [WIDTH-1:0] grant_operand;

    // A live lock masks out the other requester entirely; otherwise a tie
    // goes to whoever was not granted last.
    always_comb begin
        eligible      = lock_active ? (req & idx_to_onehot(lock_owner)) : req;
        grant_idx     = (eligible == 2'b11) ? ~rr : eligible[1];
        grant_op      = grant_idx ? op1 : op0;
        grant_operand = grant_idx ? operand1 : operand0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        gnt         = 2'b00;
        done        = 2'b00;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant_valid = 1'b1;
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                gnt        = idx_to_onehot(owner);
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                gnt        = idx_to_onehot(owner);
                done       = idx_to_onehot(owner);
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            rr        <= 1'b1;
            op_q      <= ADD;
            operand_q <= '0;
            acc_q     <= '0;
        end else begin
            if (grant_valid) begin
                owner     <= grant_idx;
                rr        <= grant_idx;
                op_q      <= grant_op;
                operand_q <= grant_operand;
            end
            if (state == EXEC) begin
                acc_q <= acc_next;
            end
        end
    end

    // Ownership is re-evaluated at every grant and released as soon as the
    // owner's lock is seen low while the accumulator is not mid-update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
        end else if (grant_valid) begin
            lock_active <= lock[grant_idx];
            lock_owner  <= grant_idx;
        end else if ((state == IDLE || state == DONE) && lock_active && !lock[lock_owner]) begin
            lock_active <= 1'b0;
        end
    end

    calc_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .acc     (acc_q),
        .operand (operand_q),
        .op      (op_q),
        .next_acc(acc_next)
    );

    assign acc    = acc_q;
    assign result = acc_q;

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/accumulator width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 2, per-requester operation request (bit i = requester i).
REQ-005 SHALL have port lock, input, 2, per-requester hold of accumulator ownership across operations.
REQ-006 SHALL have ports op0 and op1, input, 2 each, calc_op_t operation of requester 0 and 1.
REQ-007 SHALL have ports operand0 and operand1, input, WIDTH each, operand of requester 0 and 1.
REQ-008 SHALL have port gnt, output, 2, one-hot grant, high for the whole of the owning operation.
REQ-009 SHALL have port done, output, 2, one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port result, output, WIDTH, accumulator value, valid while any done bit is high.
REQ-011 SHALL have port acc, output, WIDTH, current accumulator value at all times.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DONE; IDLE->EXEC on an accepted request; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-014 SHALL sample req only in IDLE; at that edge, latch the winner's op and operand, set gnt[winner], and enter EXEC.
REQ-015 SHALL, with both requests high and no lock active, grant the requester not equal to the last-granted pointer rr; with one request high, grant it.
REQ-016 SHALL set rr to the granted index on every grant.
REQ-017 SHALL, at the EXEC->DONE edge, update acc from the latched values: ADD acc+operand, SUBTRACT acc-operand, both modulo 2^WIDTH; OR bitwise acc|operand; EQUALS acc==operand zero-extended to WIDTH (1 or 0).
REQ-018 SHALL assert done[owner] and hold gnt[owner] during DONE; result equals the updated acc.
REQ-019 SHALL give a latency of 3 cycles per operation: grant edge, update edge, return-to-IDLE edge; back-to-back grants no closer than 3 cycles.
REQ-020 SHALL complete a latched operation even if the owner drops req after the grant; done still pulses.
REQ-021 SHALL treat a req still high in IDLE after done as a new request.
REQ-022 SHALL record a lock owner when the granted requester has lock high at the grant edge.
REQ-023 SHALL, while a lock owner exists, ignore the other requester's req and grant only the owner.
REQ-024 SHALL clear the lock owner when lock[owner] is sampled low in IDLE or DONE.
REQ-025 SHALL ignore lock bits of non-granted requesters.
REQ-026 SHALL keep gnt and done at 0 in IDLE.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-operation, asynchronously force state IDLE, acc 0, gnt 0, done 0, busy 0, rr 1, lock owner cleared, latched op/operand 0.
REQ-028 SHALL NOT produce a done pulse for an operation interrupted by reset.

Structure
REQ-029 SHALL take calc_op_t (ADD 00, SUBTRACT 01, OR 10, EQUALS 11) and the FSM state enum from shared package calc_pkg.
REQ-030 SHALL compute the next accumulator in combinational sub-module calc_alu (inputs acc, operand, op; output next value), instantiated once.

Verification
REQ-031 SHALL check: reset, req=01, op0=ADD, operand0=5 -> gnt=01 after 1 edge, done[0] pulse 2 edges later, result=5, acc=5.
REQ-032 SHALL check: acc=3, requester 1 SUBTRACT 5 -> result=254 (wrap, WIDTH=8); then EQUALS 254 -> result=1; then EQUALS 7 -> result=0.
REQ-033 SHALL check: after reset both req high continuously -> grants alternate 0,1,0,1, each done to the matching requester, spacing 3 cycles.
REQ-034 SHALL check: requester 0 holds lock high with req high, requester 1 req high -> three consecutive grants to 0; lock[0] low -> next grant to 1.
REQ-035 SHALL check: rst_n pulsed low during EXEC of ADD 9 -> no done, acc=0, busy=0 immediately; next req completes normally from acc=0.
